// File: rtl/counter_pkg.sv
// Shared types and helpers for the decimal up/down counter.
// Digit type, clamp of out-of-range load digits, and integer powers of ten.
package counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit with load, carry/borrow ripple and a hold for saturation.
// Latency 1 for load/step; step_out is combinational from step_in and the digit.
module bcd_digit_cell
  import counter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       decrement,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       step_out
);

  assign step_out = step_in & (decrement ? (digit == 4'd0) : (digit == BCD_MAX_DIGIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step_in && !hold) begin
      if (decrement)
        digit <= (digit == 4'd0) ? BCD_MAX_DIGIT : digit - 4'd1;
      else
        digit <= (digit == BCD_MAX_DIGIT) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-digit decimal up/down counter with load, wrap/saturate limits and a
// binary shadow register kept in step with the BCD digits (latency 1, no backpressure).
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0,
  parameter int BIN_W    = $clog2(10**DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  decrement,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      binout,
  output logic                  wrap,
  output logic                  at_zero,
  output logic                  at_max
);

  localparam logic [4*DIGITS-1:0] MAX_BCD = {DIGITS{4'h9}};
  localparam logic [BIN_W-1:0]    MAX_BIN = BIN_W'(pow10(DIGITS) - 1);

  // step[i] is the carry/borrow into digit i; step[DIGITS] fires only when
  // an enabled step is taken at the limit, which is exactly the wrap event.
  logic [DIGITS:0]  step;
  logic             limit_step;
  logic             hold;
  logic [BIN_W-1:0] load_bin;

  assign step[0]    = enable;
  assign limit_step = step[DIGITS];
  assign hold       = SATURATE & limit_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_digit (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_digit (load_bcd[4*g +: 4]),
      .step_in    (step[g]),
      .decrement  (decrement),
      .hold       (hold),
      .digit      (bcd[4*g +: 4]),
      .step_out   (step[g+1])
    );
  end

  assign at_zero = (bcd == '0);
  assign at_max  = (bcd == MAX_BCD);

  always_comb begin
    load_bin = '0;
    for (int i = 0; i < DIGITS; i++)
      load_bin = load_bin + BIN_W'(bcd_clamp(load_bcd[4*i +: 4])) * BIN_W'(pow10(i));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      binout <= '0;
      wrap   <= 1'b0;
    end else if (load) begin
      binout <= load_bin;
      wrap   <= 1'b0;
    end else begin
      wrap <= limit_step;
      if (enable && !hold) begin
        if (decrement)
          binout <= (binout == '0) ? MAX_BIN : binout - 1'b1;
        else
          binout <= (binout == MAX_BIN) ? '0 : binout + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: wrap, saturate and 2-digit builds driven in parallel,
// checked against an integer reference model, a vector table and directed sequences.
module tb_bcd_updown_counter;

  logic        clock = 1'b0;
  logic        reset, enable, decrement, load;
  logic [15:0] load_bcd;

  logic [15:0] bcd0, bcd1;
  logic [13:0] bin0, bin1;
  logic [7:0]  bcd2;
  logic [6:0]  bin2;
  logic [2:0]  o_wrap, o_zero, o_max;

  always #5 clock = ~clock;

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .decrement(decrement),
    .load(load), .load_bcd(load_bcd), .bcd(bcd0), .binout(bin0),
    .wrap(o_wrap[0]), .at_zero(o_zero[0]), .at_max(o_max[0]));

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .decrement(decrement),
    .load(load), .load_bcd(load_bcd), .bcd(bcd1), .binout(bin1),
    .wrap(o_wrap[1]), .at_zero(o_zero[1]), .at_max(o_max[1]));

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .decrement(decrement),
    .load(load), .load_bcd(load_bcd[7:0]), .bcd(bcd2), .binout(bin2),
    .wrap(o_wrap[2]), .at_zero(o_zero[2]), .at_max(o_max[2]));

  logic [31:0] o_bcd [3];
  logic [31:0] o_bin [3];
  assign o_bcd[0] = {16'h0, bcd0};
  assign o_bcd[1] = {16'h0, bcd1};
  assign o_bcd[2] = {24'h0, bcd2};
  assign o_bin[0] = {18'h0, bin0};
  assign o_bin[1] = {18'h0, bin1};
  assign o_bin[2] = {25'h0, bin2};

  // Reference model: the count as a plain integer per instance.
  int cnt [3];
  bit mw  [3];
  int mx  [3] = '{9999, 9999, 99};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  int nd  [3] = '{4, 4, 2};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k);
    if (reset) begin
      cnt[k] = 0;
      mw[k]  = 1'b0;
    end else if (load) begin
      int v;
      v = 0;
      for (int i = nd[k] - 1; i >= 0; i--) begin
        int d;
        d = int'(load_bcd[4*i +: 4]);
        if (d > 9) d = 9;
        v = v * 10 + d;
      end
      cnt[k] = v;
      mw[k]  = 1'b0;
    end else if (enable) begin
      if (!decrement) begin
        mw[k] = (cnt[k] == mx[k]);
        if (!mw[k]) cnt[k] = cnt[k] + 1;
        else if (!sat[k]) cnt[k] = 0;
      end else begin
        mw[k] = (cnt[k] == 0);
        if (!mw[k]) cnt[k] = cnt[k] - 1;
        else if (!sat[k]) cnt[k] = mx[k];
      end
    end else begin
      mw[k] = 1'b0;
    end
  endtask

  task automatic check_inst(input int k);
    chk($sformatf("model bcd[%0d]", k), o_bcd[k], to_bcd(cnt[k], nd[k]));
    chk($sformatf("model bin[%0d]", k), o_bin[k], 32'(cnt[k]));
    chk($sformatf("model wrap[%0d]", k), 32'(o_wrap[k]), 32'(mw[k]));
    chk($sformatf("model at_zero[%0d]", k), 32'(o_zero[k]), 32'(cnt[k] == 0));
    chk($sformatf("model at_max[%0d]", k), 32'(o_max[k]), 32'(cnt[k] == mx[k]));
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) check_inst(k);
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic l,
                       input logic [15:0] v);
    reset = r; enable = e; decrement = d; load = l; load_bcd = v;
  endtask

  typedef struct {
    logic        rst, en, dec, ld;
    logic [15:0] ldv;
    logic [15:0] exp_bcd;
    int          exp_bin;
    logic        exp_wrap;
  } vec_t;

  vec_t tbl [15];
  bit   wrap_seen;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; mw[k] = 1'b0; end

    //             rst   en    dec   ld    load      bcd       bin   wrap
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,    1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h12A5, 16'h1295, 1295, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 16'h0042, 42,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0043, 43,   1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0042, 42,   1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 100,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0099, 99,   1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h9999, 9999, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,    1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999, 9999, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 9999, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0500, 16'h0500, 500,  1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0501, 501,  1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 0,    1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,    1'b0};

    tick();
    chk("reset bcd", o_bcd[0], 32'h0);
    chk("reset binout", o_bin[0], 32'h0);
    chk("reset at_zero", 32'(o_zero[0]), 32'h1);
    chk("reset at_max", 32'(o_max[0]), 32'h0);
    chk("reset wrap", 32'(o_wrap[0]), 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].dec, tbl[i].ld, tbl[i].ldv);
      tick();
      chk($sformatf("tbl[%0d] bcd", i), o_bcd[0], {16'h0, tbl[i].exp_bcd});
      chk($sformatf("tbl[%0d] bin", i), o_bin[0], 32'(tbl[i].exp_bin));
      chk($sformatf("tbl[%0d] wrap", i), 32'(o_wrap[0]), 32'(tbl[i].exp_wrap));
    end

    // 1024 steps up then back down, never touching a limit.
    wrap_seen = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (1024) begin tick(); wrap_seen |= o_wrap[0]; end
    chk("up1024 bcd", o_bcd[0], 32'h1024);
    chk("up1024 bin", o_bin[0], 32'd1024);
    decrement = 1'b1;
    repeat (1024) begin tick(); wrap_seen |= o_wrap[0]; end
    chk("down1024 bcd", o_bcd[0], 32'h0);
    chk("down1024 bin", o_bin[0], 32'd0);
    chk("no wrap during 1024 run", 32'(wrap_seen), 32'h0);

    // Count to the top, then step past it in both modes.
    decrement = 1'b0;
    repeat (9999) tick();
    chk("at_max wrap-mode", 32'(o_max[0]), 32'h1);
    chk("at_max sat-mode", 32'(o_max[1]), 32'h1);
    tick();
    chk("overflow bcd", o_bcd[0], 32'h0);
    chk("overflow wrap", 32'(o_wrap[0]), 32'h1);
    chk("sat overflow bcd", o_bcd[1], 32'h9999);
    chk("sat overflow wrap", 32'(o_wrap[1]), 32'h1);
    decrement = 1'b1;
    tick();
    chk("underflow bcd", o_bcd[0], 32'h9999);
    chk("underflow bin", o_bin[0], 32'd9999);
    chk("underflow wrap", 32'(o_wrap[0]), 32'h1);
    enable = 1'b0;
    tick();
    chk("wrap one cycle", 32'(o_wrap[0]), 32'h0);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("sat hold zero %0d bcd", i), o_bcd[1], 32'h0);
      chk($sformatf("sat hold zero %0d wrap", i), 32'(o_wrap[1]), 32'h1);
    end

    // Two-digit build wraps 99 -> 0.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0099);
    tick();
    chk("d2 load 99", o_bcd[2], 32'h99);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("d2 overflow bcd", o_bcd[2], 32'h0);
    chk("d2 overflow bin", o_bin[2], 32'h0);
    chk("d2 overflow wrap", 32'(o_wrap[2]), 32'h1);

    // Random traffic, with loads biased toward the limits.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = 16'h9999;
        1: v = 16'h9998;
        2: v = 16'h0001;
        default: ;
      endcase
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 15) == 0), v);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
